// File: rtl/bpi_bus_engine_if.sv
// Sequencer-facing handshake of the BPI bus engine: request, operands and status/read data.
interface bpi_bus_engine_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
);
  logic              EXECUTE;
  logic              READ;
  logic [ADDR_W-1:0] ADDR_IN;
  logic [DATA_W-1:0] DATA_IN;
  logic              BUSY;
  logic              RDY;
  logic              LD_DAT;
  logic [DATA_W-1:0] DATA_OUT;

  modport master (output EXECUTE, READ, ADDR_IN, DATA_IN,
                  input  BUSY, RDY, LD_DAT, DATA_OUT);
  modport slave  (input  EXECUTE, READ, ADDR_IN, DATA_IN,
                  output BUSY, RDY, LD_DAT, DATA_OUT);
endinterface

// File: rtl/bpi_bus_engine.sv
// BPI flash bus engine: one timed asynchronous NOR read or write per EXECUTE, every pad output registered.
// RDY returns accept+3+T_WE+T_REC (write) / accept+3+T_RD+T_REC (read); EXECUTE ignored unless idle and re-armed.
module bpi_bus_engine #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int T_WE   = 4,
  parameter int T_RD   = 6,
  parameter int T_REC  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  bpi_bus_engine_if.slave   seq,
  output logic [ADDR_W-1:0] FLASH_A,
  input  logic [DATA_W-1:0] FLASH_DQ_I,
  output logic [DATA_W-1:0] FLASH_DQ_O,
  output logic              FLASH_DQ_OE,
  output logic              FLASH_CE_B,
  output logic              FLASH_OE_B,
  output logic              FLASH_WE_B
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WR_PULSE, S_HOLD, S_RD_WAIT, S_CAPTURE, S_RECOVER
  } state_t;

  // A zero timing parameter behaves as one cycle.
  localparam logic [7:0] WE_LD  = 8'((T_WE  < 1 ? 1 : T_WE)  - 1);
  localparam logic [7:0] RD_LD  = 8'((T_RD  < 1 ? 1 : T_RD)  - 1);
  localparam logic [7:0] REC_LD = 8'((T_REC < 1 ? 1 : T_REC) - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;

  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
  logic              ld_dat_q, ld_dat_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_b_q, ce_b_d;
  logic              oe_b_q, oe_b_d;
  logic              we_b_q, we_b_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q | ~seq.EXECUTE;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    case (state_q)
      S_IDLE: begin
        // armed only re-arms after a low EXECUTE cycle, so a stuck request runs once.
        if (seq.EXECUTE && armed_q) begin
          state_d = S_SETUP;
          armed_d = 1'b0;
          rd_d    = seq.READ;
          addr_d  = seq.ADDR_IN;
          wdat_d  = seq.DATA_IN;
        end
      end
      S_SETUP: begin
        state_d = rd_q ? S_RD_WAIT : S_WR_PULSE;
        cnt_d   = rd_q ? RD_LD : WE_LD;
      end
      S_WR_PULSE: begin
        if (cnt_q == 8'd0) state_d = S_HOLD;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_HOLD: begin
        state_d = S_RECOVER;
        cnt_d   = REC_LD;
      end
      S_RD_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_CAPTURE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_CAPTURE: begin
        state_d = S_RECOVER;
        cnt_d   = REC_LD;
      end
      S_RECOVER: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pad and status flops present the current state one cycle later, so every pin leaves a flop.
  always_comb begin
    busy_d     = 1'b0;
    rdy_d      = 1'b0;
    ld_dat_d   = 1'b0;
    data_out_d = data_out_q;
    fa_d       = fa_q;
    dq_o_d     = dq_o_q;
    dq_oe_d    = 1'b0;
    ce_b_d     = 1'b1;
    oe_b_d     = 1'b1;
    we_b_d     = 1'b1;
    case (state_q)
      S_IDLE: rdy_d = 1'b1;
      S_SETUP: begin
        busy_d  = 1'b1;
        ce_b_d  = 1'b0;
        fa_d    = addr_q;
        dq_oe_d = ~rd_q;
        if (!rd_q) dq_o_d = wdat_q;
      end
      S_WR_PULSE: begin
        busy_d  = 1'b1;
        ce_b_d  = 1'b0;
        we_b_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      S_HOLD: begin
        busy_d  = 1'b1;
        ce_b_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      S_RD_WAIT: begin
        busy_d = 1'b1;
        ce_b_d = 1'b0;
        oe_b_d = 1'b0;
      end
      S_CAPTURE: begin
        // Samples DQ at the end of the last pad cycle with OE_B low: a full T_RD of access time.
        busy_d     = 1'b1;
        ce_b_d     = 1'b0;
        ld_dat_d   = 1'b1;
        data_out_d = FLASH_DQ_I;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q     <= 1'b0;
      rdy_q      <= 1'b1;
      ld_dat_q   <= 1'b0;
      data_out_q <= '0;
      fa_q       <= '0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      ce_b_q     <= 1'b1;
      oe_b_q     <= 1'b1;
      we_b_q     <= 1'b1;
    end else begin
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
      ld_dat_q   <= ld_dat_d;
      data_out_q <= data_out_d;
      fa_q       <= fa_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
      ce_b_q     <= ce_b_d;
      oe_b_q     <= oe_b_d;
      we_b_q     <= we_b_d;
    end
  end

  assign seq.BUSY     = busy_q;
  assign seq.RDY      = rdy_q;
  assign seq.LD_DAT   = ld_dat_q;
  assign seq.DATA_OUT = data_out_q;
  assign FLASH_A      = fa_q;
  assign FLASH_DQ_O   = dq_o_q;
  assign FLASH_DQ_OE  = dq_oe_q;
  assign FLASH_CE_B   = ce_b_q;
  assign FLASH_OE_B   = oe_b_q;
  assign FLASH_WE_B   = we_b_q;

endmodule

// File: tb/tb_bpi_bus_engine.sv
// Bench for bpi_bus_engine: default-timed and minimum-timed instances against a per-access timeline model.
module tb_bpi_bus_engine;

  localparam int T_WE_A = 4, T_RD_A = 6, T_REC_A = 2;
  localparam int T_WE_B = 0, T_RD_B = 1, T_REC_B = 0;

  typedef struct packed {
    logic        busy;
    logic        rdy;
    logic        ld;
    logic [15:0] dout;
    logic [22:0] a;
    logic [15:0] dqo;
    logic        dq_oe;
    logic        ce_b;
    logic        oe_b;
    logic        we_b;
  } obs_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        execute, rd;
  logic [22:0] addr;
  logic [15:0] wdat, dq_i;

  bpi_bus_engine_if #(.ADDR_W(23), .DATA_W(16)) sa ();
  bpi_bus_engine_if #(.ADDR_W(23), .DATA_W(16)) sb ();

  logic [22:0] a_fa, b_fa;
  logic [15:0] a_dqo, b_dqo;
  logic        a_dq_oe, a_ce, a_oe, a_we, b_dq_oe, b_ce, b_oe, b_we;

  assign sa.EXECUTE = execute;  assign sb.EXECUTE = execute;
  assign sa.READ    = rd;       assign sb.READ    = rd;
  assign sa.ADDR_IN = addr;     assign sb.ADDR_IN = addr;
  assign sa.DATA_IN = wdat;     assign sb.DATA_IN = wdat;

  bpi_bus_engine #(.ADDR_W(23), .DATA_W(16), .T_WE(T_WE_A), .T_RD(T_RD_A), .T_REC(T_REC_A)) dut_a (
    .CLK(CLK), .RST(RST), .seq(sa.slave), .FLASH_A(a_fa), .FLASH_DQ_I(dq_i), .FLASH_DQ_O(a_dqo),
    .FLASH_DQ_OE(a_dq_oe), .FLASH_CE_B(a_ce), .FLASH_OE_B(a_oe), .FLASH_WE_B(a_we));

  bpi_bus_engine #(.ADDR_W(23), .DATA_W(16), .T_WE(T_WE_B), .T_RD(T_RD_B), .T_REC(T_REC_B)) dut_b (
    .CLK(CLK), .RST(RST), .seq(sb.slave), .FLASH_A(b_fa), .FLASH_DQ_I(dq_i), .FLASH_DQ_O(b_dqo),
    .FLASH_DQ_OE(b_dq_oe), .FLASH_CE_B(b_ce), .FLASH_OE_B(b_oe), .FLASH_WE_B(b_we));

  obs_t obs [2];
  assign obs[0] = {sa.BUSY, sa.RDY, sa.LD_DAT, sa.DATA_OUT, a_fa, a_dqo, a_dq_oe, a_ce, a_oe, a_we};
  assign obs[1] = {sb.BUSY, sb.RDY, sb.LD_DAT, sb.DATA_OUT, b_fa, b_dqo, b_dq_oe, b_ce, b_oe, b_we};

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int t);
    return (t < 1) ? 1 : t;
  endfunction
  function automatic int span(input int d, input bit is_rd);
    if (is_rd) return eff(d == 0 ? T_RD_A : T_RD_B);
    return eff(d == 0 ? T_WE_A : T_WE_B);
  endfunction
  function automatic int rdy_n(input int d, input bit is_rd);
    return 3 + span(d, is_rd) + eff(d == 0 ? T_REC_A : T_REC_B);
  endfunction

  task automatic cmp(input int d, input obs_t g, input obs_t e);
    string p;
    p = (d == 0) ? "a." : "b.";
    chk({p, "busy"},     32'(g.busy),  32'(e.busy));
    chk({p, "rdy"},      32'(g.rdy),   32'(e.rdy));
    chk({p, "ld_dat"},   32'(g.ld),    32'(e.ld));
    chk({p, "data_out"}, 32'(g.dout),  32'(e.dout));
    chk({p, "flash_a"},  32'(g.a),     32'(e.a));
    chk({p, "dq_o"},     32'(g.dqo),   32'(e.dqo));
    chk({p, "dq_oe"},    32'(g.dq_oe), 32'(e.dq_oe));
    chk({p, "ce_b"},     32'(g.ce_b),  32'(e.ce_b));
    chk({p, "oe_b"},     32'(g.oe_b),  32'(e.oe_b));
    chk({p, "we_b"},     32'(g.we_b),  32'(e.we_b));
  endtask

  // Model: each access is a timeline indexed by cycles since the accepting edge.
  bit          act [2];
  bit          armed [2];
  bit          mrd [2];
  int          nn [2];
  logic [22:0] madr [2], ea [2];
  logic [15:0] mdat [2], edqo [2], edout [2];
  int          we_run [2], oe_run [2], ce_hi [2], busy_rise [2], ld_cnt [2];
  logic        prev_busy [2];

  always @(posedge CLK) begin
    obs_t e;
    int   n, l;
    bit   on, ph;
    for (int d = 0; d < 2; d++) begin
      if (RST) begin
        act[d] = 0; nn[d] = 0; armed[d] = 1;
        ea[d] = '0; edqo[d] = '0; edout[d] = '0;
      end else begin
        if (act[d]) begin
          nn[d]++;
          if (nn[d] >= rdy_n(d, mrd[d])) act[d] = 0;
        end
        if (!act[d] && execute && armed[d]) begin
          act[d] = 1; nn[d] = 0; armed[d] = 0;
          mrd[d] = rd; madr[d] = addr; mdat[d] = wdat;
        end else if (!execute) begin
          armed[d] = 1;
        end
        if (act[d] && nn[d] == 1) begin
          ea[d] = madr[d];
          if (!mrd[d]) edqo[d] = mdat[d];
        end
        if (act[d] && mrd[d] && nn[d] == 2 + span(d, 1'b1)) edout[d] = dq_i;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      n  = nn[d];
      l  = span(d, mrd[d]);
      on = act[d] && n >= 1 && n <= 2 + l;
      ph = act[d] && n >= 2 && n <= 1 + l;
      e.busy  = on;
      e.rdy   = !act[d] || n == 0;
      e.ld    = act[d] && mrd[d] && n == 2 + l;
      e.dout  = edout[d];
      e.a     = ea[d];
      e.dqo   = edqo[d];
      e.dq_oe = on && !mrd[d];
      e.ce_b  = !on;
      e.oe_b  = !(ph && mrd[d]);
      e.we_b  = !(ph && !mrd[d]);
      cmp(d, obs[d], e);
      if (RST) begin
        we_run[d] = 0; oe_run[d] = 0;
      end else begin
        if (!obs[d].we_b) we_run[d]++;
        else if (we_run[d] > 0) begin
          chk(d == 0 ? "a.we_width" : "b.we_width", 32'(we_run[d]), 32'(span(d, 1'b0)));
          we_run[d] = 0;
        end
        if (!obs[d].oe_b) oe_run[d]++;
        else if (oe_run[d] > 0) begin
          chk(d == 0 ? "a.oe_width" : "b.oe_width", 32'(oe_run[d]), 32'(span(d, 1'b1)));
          oe_run[d] = 0;
        end
      end
      if (obs[d].ce_b) ce_hi[d]++;
      else if (ce_hi[d] > 0) begin
        chk(d == 0 ? "a.ce_gap_ge2" : "b.ce_gap_ge2", 32'(ce_hi[d] >= 2), 32'd1);
        ce_hi[d] = 0;
      end
      if (obs[d].busy && !prev_busy[d]) busy_rise[d]++;
      if (obs[d].ld) ld_cnt[d]++;
      prev_busy[d] = obs[d].busy;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 40 && !sa.BUSY; i++) step();
    chk("busy_seen", 32'(sa.BUSY), 32'd1);
  endtask

  task automatic wait_rdy(output int n);
    for (n = 0; n < 100 && !sa.RDY; n++) step();
    chk("rdy_seen", 32'(sa.RDY), 32'd1);
  endtask

  task automatic issue(input bit r, input logic [22:0] ad, input logic [15:0] dt);
    rd = r; addr = ad; wdat = dt; execute = 1'b1;
    wait_busy();
    execute = 1'b0;
  endtask

  initial begin
    int n, r0, r1, l0;
    RST = 1'b1; execute = 1'b0; rd = 1'b0; addr = '0; wdat = '0; dq_i = '0;
    repeat (3) step();
    chk("rst_rdy", 32'(sa.RDY), 32'd1);
    chk("rst_ce_b", 32'(a_ce), 32'd1);
    chk("rst_dq_oe", 32'(a_dq_oe), 32'd0);
    RST = 1'b0;
    step();

    issue(1'b0, 23'h12345, 16'hA5C3);
    wait_rdy(n);
    chk("wr_rdy_latency", 32'(n + 1), 32'd9);
    chk("wr_addr", 32'(a_fa), 32'h12345);
    chk("wr_dq_o", 32'(a_dqo), 32'hA5C3);

    dq_i = 16'h5A5A;
    l0 = ld_cnt[0];
    issue(1'b1, 23'h7FFFFF, 16'h0000);
    wait_rdy(n);
    chk("rd_rdy_latency", 32'(n + 1), 32'd11);
    chk("rd_data", 32'(sa.DATA_OUT), 32'h5A5A);
    chk("rd_ld_pulses", 32'(ld_cnt[0] - l0), 32'd1);

    r0 = busy_rise[0]; r1 = busy_rise[1];
    issue(1'b0, 23'h00ABC, 16'h1234);
    wait_rdy(n);
    issue(1'b1, 23'h055AA, 16'h0000);
    wait_rdy(n);
    issue(1'b0, 23'h3FF00, 16'hBEEF);
    wait_rdy(n);
    chk("b2b_accepts_a", 32'(busy_rise[0] - r0), 32'd3);
    chk("b2b_accepts_b", 32'(busy_rise[1] - r1), 32'd3);
    chk("b2b_dout_hold", 32'(sa.DATA_OUT), 32'h5A5A);
    chk("b2b_addr", 32'(a_fa), 32'h3FF00);

    r0 = busy_rise[0]; r1 = busy_rise[1];
    rd = 1'b0; addr = 23'h00F0F; wdat = 16'h0F0F; execute = 1'b1;
    repeat (30) step();
    chk("stuck_one_access_a", 32'(busy_rise[0] - r0), 32'd1);
    chk("stuck_one_access_b", 32'(busy_rise[1] - r1), 32'd1);
    chk("stuck_rdy_held", 32'(sa.RDY), 32'd1);
    execute = 1'b0;
    step();
    execute = 1'b1;
    wait_busy();
    execute = 1'b0;
    chk("rearm_new_access", 32'(busy_rise[0] - r0), 32'd2);
    wait_rdy(n);

    l0 = ld_cnt[0];
    issue(1'b0, 23'h00001, 16'hFFFF);
    for (int i = 0; i < 20 && a_we; i++) step();
    chk("we_low_seen", 32'(a_we), 32'd0);
    step();
    RST = 1'b1;
    #1;
    chk("rst_mid_we_b", 32'(a_we), 32'd1);
    chk("rst_mid_ce_b", 32'(a_ce), 32'd1);
    chk("rst_mid_dq_oe", 32'(a_dq_oe), 32'd0);
    chk("rst_mid_rdy", 32'(sa.RDY), 32'd1);
    chk("rst_mid_busy", 32'(sa.BUSY), 32'd0);
    step();
    step();
    RST = 1'b0;
    step();
    chk("rst_mid_no_ld", 32'(ld_cnt[0] - l0), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      execute = ($urandom_range(0, 2) != 0);
      rd      = 1'($urandom_range(0, 1));
      addr    = 23'($urandom);
      wdat    = 16'($urandom);
      if (!act[0] && !act[1]) dq_i = 16'($urandom);
      step();
    end
    execute = 1'b0;
    wait_rdy(n);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
